// File: rtl/host_spi_master.sv
// host_spi_master: DW-bit SPI master with SCK divider, per-frame CPOL/CPHA, NCS chip selects and a CSN gap.
// Define HOST_SPI_LSB_FIRST_EN to shift frames LSB first; otherwise frames are shifted MSB first.
module host_spi_master #(
  parameter int DW       = 40,
  parameter int RX       = 18,
  parameter int CLK_DIV  = 2,
  parameter int NCS      = 1,
  parameter int GAP_HALF = 2,
  localparam int CSW     = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spi_start,
  input  logic           spi_cpol,
  input  logic           spi_cpha,
  input  logic [CSW-1:0] spi_cs_sel,
  input  logic [DW-1:0]  spi_tx_data,
  output logic           spi_busy,
  output logic           spi_complete,
  output logic [RX-1:0]  spi_rx_data,
  output logic           spi_rx_valid,
  output logic           spi_sck,
  output logic [NCS-1:0] spi_csn,
  output logic           spi_mosi,
  input  logic           spi_miso
);
  localparam int CW   = $clog2(CLK_DIV) + 1;
  localparam int MAXT = (2 * DW > GAP_HALF) ? 2 * DW : GAP_HALF;
  localparam int TW   = $clog2(MAXT) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  half_q, half_d;
  logic           cpol_q, cpol_d, cpha_q, cpha_d, sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;
  logic [NCS-1:0] csn_q, csn_d, sel_n;
  logic [DW-1:0]  tx_q, tx_d, tx_shift_in, tx_shift_q;
  logic           tx_head_in, tx_head_q;
  logic [RX-1:0]  rx_sh_q, rx_sh_d, rx_shift, rx_q, rx_d;
  logic           tick, lead, half_last, gap_last, accept, shift_tick, sample, launch, hold_end, done;

`ifdef HOST_SPI_LSB_FIRST_EN
  assign tx_head_in  = spi_tx_data[0];
  assign tx_shift_in = spi_tx_data >> 1;
  assign tx_head_q   = tx_q[0];
  assign tx_shift_q  = tx_q >> 1;
  assign rx_shift    = RX'({spi_miso, rx_sh_q} >> 1);
`else
  assign tx_head_in  = spi_tx_data[DW-1];
  assign tx_shift_in = spi_tx_data << 1;
  assign tx_head_q   = tx_q[DW-1];
  assign tx_shift_q  = tx_q << 1;
  assign rx_shift    = RX'({rx_sh_q, spi_miso});
`endif

  always_comb begin
    tick       = cnt_q == CW'(CLK_DIV - 1);
    lead       = ~half_q[0];
    half_last  = half_q == TW'(2 * DW - 1);
    gap_last   = half_q == TW'(GAP_HALF - 1);
    accept     = (state_q == IDLE) && spi_start;
    shift_tick = (state_q == SHIFT) && tick;
    sample     = shift_tick && (lead ^ cpha_q);
    launch     = shift_tick && (cpha_q ? lead : (!lead && !half_last));
    hold_end   = (state_q == HOLD) && tick;
    done       = (state_q == GAP) && tick && gap_last;
  end

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NCS; i++)
      if (spi_cs_sel == CSW'(i)) sel_n[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = spi_start ? SETUP : IDLE;
      SETUP:   state_d = tick ? SHIFT : SETUP;
      SHIFT:   state_d = (tick && half_last) ? HOLD : SHIFT;
      HOLD:    state_d = tick ? GAP : HOLD;
      GAP:     state_d = (tick && gap_last) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
    half_d  = (state_d != state_q || state_q == IDLE) ? '0 : half_q + TW'(tick);
    cpol_d  = accept ? spi_cpol : cpol_q;
    cpha_d  = accept ? spi_cpha : cpha_q;
    sck_d   = accept ? spi_cpol : shift_tick ? (lead ? ~cpol_q : cpol_q) : sck_q;
    csn_d   = accept ? sel_n : hold_end ? '1 : csn_q;
    mosi_d  = accept ? (spi_cpha ? mosi_q : tx_head_in) : hold_end ? 1'b0 : launch ? tx_head_q : mosi_q;
    tx_d    = accept ? (spi_cpha ? spi_tx_data : tx_shift_in) : launch ? tx_shift_q : tx_q;
    rx_sh_d = accept ? '0 : sample ? rx_shift : rx_sh_q;
    rx_d    = done ? rx_sh_q : rx_q;
    done_d  = done;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      half_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sck_q   <= 1'b0;
      csn_q   <= '1;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end

  assign spi_busy     = state_q != IDLE;
  assign spi_complete = done_q;
  assign spi_rx_valid = done_q;
  assign spi_rx_data  = rx_q;
  assign spi_sck      = sck_q;
  assign spi_csn      = csn_q;
  assign spi_mosi     = mosi_q;
endmodule
